action: RTL and testbench

- Sprite-animation controller for the VGA dog display, clocked by the pixel clock.
- Divides pixel_clk down to an animation tick.
- On each tick, moves the dog back and forth across the screen and selects the sprite frame.
- Downstream renderer uses ActionSel as the sprite-ROM index and DogPos_x/DogPos_y as the sprite's top-left corner.

---
 rtl/action_pkg.sv | 33 +++
 rtl/action_tick_gen.sv | 36 +++
 rtl/action.sv | 166 ++++++++++++++++
 tb/tb_action.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/action_pkg.sv
// Shared types and constants for the dog sprite-animation controller.
package action_pkg;

  // Screen and sprite geometry in pixels.
  localparam int unsigned SCREEN_W  = 640;
  localparam int unsigned SCREEN_H  = 480;
  localparam int unsigned SPRITE_SZ = 64;

  // Animation FSM states; the jump states only exist in ACTION_JUMP_EN builds.
  typedef enum logic [2:0] {
    StWalkR,
    StWalkL,
    StSit,
    StJumpUp,
    StJumpDn
  } state_e;

  // Wall the dog last reached; decides which way it walks after sitting/jumping.
  typedef enum logic {
    DirRight,
    DirLeft
  } dir_e;

  // Sprite-ROM frame indices driven on ActionSel (7 is reserved).
  localparam logic [2:0] FRM_WR0 = 3'd0;
  localparam logic [2:0] FRM_WR1 = 3'd1;
  localparam logic [2:0] FRM_WL0 = 3'd2;
  localparam logic [2:0] FRM_WL1 = 3'd3;
  localparam logic [2:0] FRM_SIT = 3'd4;
  localparam logic [2:0] FRM_JUP = 3'd5;
  localparam logic [2:0] FRM_JDN = 3'd6;

endpackage

// File: rtl/action_tick_gen.sv
// Divides the pixel clock down to a one-cycle animation tick; run=0 holds the count.
module tick_gen #(
  parameter int unsigned TICK_DIV = 2500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic tick_o
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Tick on the last count while running, then wrap; otherwise count only when running.
  always_comb begin
    tick_o = run_i && (cnt_q == CntLast);
    cnt_d  = cnt_q;
    if (tick_o) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/action.sv
// Dog sprite-animation controller: walks the dog between the walls, sitting at each wall.
// Define ACTION_JUMP_EN to replace the sit with a jump (uses STEP_Y and JUMP_H).
module action
  import action_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 2500000,
  parameter int unsigned STEP_X    = 16,
  parameter int unsigned X_MIN     = 0,
  parameter int unsigned X_MAX     = SCREEN_W - SPRITE_SZ,
  parameter int unsigned Y_GROUND  = 400,
`ifdef ACTION_JUMP_EN
  parameter int unsigned STEP_Y    = 8,
  parameter int unsigned JUMP_H    = 64,
`endif
  parameter int unsigned SIT_TICKS = 10
) (
  input  logic       pixel_clk,
  input  logic       reset,
  input  logic       run,
  output logic [2:0] ActionSel,
  output logic [9:0] DogPos_x,
  output logic [8:0] DogPos_y
);

  localparam int unsigned SitW = (SIT_TICKS > 1) ? $clog2(SIT_TICKS) : 1;
  localparam logic [SitW-1:0] SitLast = SitW'(SIT_TICKS - 1);
  localparam logic [9:0] XMin = 10'(X_MIN);
  localparam logic [9:0] XMax = 10'(X_MAX);
  localparam logic [8:0] YGround = 9'(Y_GROUND);

  logic tick;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk_i (pixel_clk),
    .rst_i (reset),
    .run_i (run),
    .tick_o(tick)
  );

  state_e          state_q, state_d;
  dir_e            dir_q, dir_d;
  logic [SitW-1:0] sit_q, sit_d;
  logic [2:0]      frm_q, frm_d;
  logic [9:0]      x_q, x_d;

`ifdef ACTION_JUMP_EN
  localparam int unsigned YApexI = Y_GROUND - JUMP_H;
  localparam logic [8:0] YApex = 9'(YApexI);
  logic [8:0] y_q, y_d;
`endif

  // Next-state logic: everything advances only on an animation tick.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    sit_d   = sit_q;
    frm_d   = frm_q;
    x_d     = x_q;
`ifdef ACTION_JUMP_EN
    y_d     = y_q;
`endif
    if (tick) begin
      case (state_q)
        StWalkR: begin
          // Compare before adding so x saturates at X_MAX for any STEP_X.
          if (32'(x_q) + STEP_X >= X_MAX) x_d = XMax;
          else                            x_d = x_q + 10'(STEP_X);
          frm_d = (frm_q == FRM_WR0) ? FRM_WR1 : FRM_WR0;
          if (x_d == XMax) begin
            dir_d = DirRight;
            sit_d = '0;
`ifdef ACTION_JUMP_EN
            state_d = StJumpUp;
            frm_d   = FRM_JUP;
`else
            state_d = StSit;
            frm_d   = FRM_SIT;
`endif
          end
        end
        StWalkL: begin
          // Compare before subtracting so x never underflows below X_MIN.
          if (32'(x_q) <= X_MIN + STEP_X) x_d = XMin;
          else                            x_d = x_q - 10'(STEP_X);
          frm_d = (frm_q == FRM_WL0) ? FRM_WL1 : FRM_WL0;
          if (x_d == XMin) begin
            dir_d = DirLeft;
            sit_d = '0;
`ifdef ACTION_JUMP_EN
            state_d = StJumpUp;
            frm_d   = FRM_JUP;
`else
            state_d = StSit;
            frm_d   = FRM_SIT;
`endif
          end
        end
`ifdef ACTION_JUMP_EN
        StJumpUp: begin
          if (32'(y_q) <= YApexI + STEP_Y) y_d = YApex;
          else                             y_d = y_q - 9'(STEP_Y);
          frm_d = FRM_JUP;
          if (y_d == YApex) state_d = StJumpDn;
        end
        StJumpDn: begin
          if (32'(y_q) + STEP_Y >= Y_GROUND) y_d = YGround;
          else                               y_d = y_q + 9'(STEP_Y);
          frm_d = FRM_JDN;
          if (y_d == YGround) begin
            state_d = (dir_q == DirRight) ? StWalkL : StWalkR;
            frm_d   = (dir_q == DirRight) ? FRM_WL0 : FRM_WR0;
          end
        end
`else
        StSit: begin
          if (sit_q == SitLast) begin
            sit_d   = '0;
            state_d = (dir_q == DirRight) ? StWalkL : StWalkR;
            frm_d   = (dir_q == DirRight) ? FRM_WL0 : FRM_WR0;
          end else begin
            sit_d = sit_q + 1'b1;
          end
        end
`endif
        default: begin
          state_d = StWalkR;
          frm_d   = FRM_WR0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset to the starting pose.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state_q <= StWalkR;
      dir_q   <= DirRight;
      sit_q   <= '0;
      frm_q   <= FRM_WR0;
      x_q     <= XMin;
`ifdef ACTION_JUMP_EN
      y_q     <= YGround;
`endif
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      sit_q   <= sit_d;
      frm_q   <= frm_d;
      x_q     <= x_d;
`ifdef ACTION_JUMP_EN
      y_q     <= y_d;
`endif
    end
  end

  assign ActionSel = frm_q;
  assign DogPos_x  = x_q;
`ifdef ACTION_JUMP_EN
  assign DogPos_y  = y_q;
`else
  assign DogPos_y  = YGround;
`endif

endmodule

// File: tb/tb_action.sv
// Directed bench for the action controller (TICK_DIV=4, STEP_X=16, X_MAX=64, SIT_TICKS=2).
module tb_action;

  logic       pixel_clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic [2:0] ActionSel;
  logic [9:0] DogPos_x;
  logic [8:0] DogPos_y;

  int total = 0;
  int bad = 0;

  action #(
    .TICK_DIV (4),
    .STEP_X   (16),
    .X_MIN    (0),
    .X_MAX    (64),
    .Y_GROUND (400),
    .SIT_TICKS(2)
  ) dut (
    .pixel_clk(pixel_clk),
    .reset    (reset),
    .run      (run),
    .ActionSel(ActionSel),
    .DogPos_x (DogPos_x),
    .DogPos_y (DogPos_y)
  );

  always #5 pixel_clk = ~pixel_clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge pixel_clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    run   = 1'b0;
    step(2);
    total++;
    if ({ActionSel, DogPos_x, DogPos_y} !== {3'd0, 10'd0, 9'd400}) begin
      bad++;
      $display("FAIL reset_pose: got as=%0d x=%0d y=%0d, want as=0 x=0 y=400",
               ActionSel, DogPos_x, DogPos_y);
    end
    reset = 1'b0;
    step(20);
    total++;
    if ({ActionSel, DogPos_x, DogPos_y} !== {3'd0, 10'd0, 9'd400}) begin
      bad++;
      $display("FAIL idle_hold: got as=%0d x=%0d y=%0d, want as=0 x=0 y=400",
               ActionSel, DogPos_x, DogPos_y);
    end
  endtask

  // First tick lands exactly 4 edges after run rises, proving the counter stayed at 0.
  task automatic test_walk_right();
    logic [2:0] e_as [4] = '{3'd1, 3'd0, 3'd1, 3'd4};
    logic [9:0] e_x  [4] = '{10'd16, 10'd32, 10'd48, 10'd64};
    run = 1'b1;
    step(3);
    total++;
    if (DogPos_x !== 10'd0 || ActionSel !== 3'd0) begin
      bad++;
      $display("FAIL walk_r_early: got as=%0d x=%0d, want as=0 x=0", ActionSel, DogPos_x);
    end
    step(1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step(4);
      total++;
      if ({ActionSel, DogPos_x, DogPos_y} !== {e_as[i], e_x[i], 9'd400}) begin
        bad++;
        $display("FAIL walk_r_tick%0d: got as=%0d x=%0d y=%0d, want as=%0d x=%0d y=400",
                 i + 1, ActionSel, DogPos_x, DogPos_y, e_as[i], e_x[i]);
      end
    end
  endtask

  task automatic test_sit_walk_left();
    logic [2:0] e_as [9] = '{3'd4, 3'd2, 3'd3, 3'd2, 3'd3, 3'd4, 3'd4, 3'd0, 3'd1};
    logic [9:0] e_x  [9] = '{10'd64, 10'd64, 10'd48, 10'd32, 10'd16, 10'd0, 10'd0, 10'd0,
                             10'd16};
    for (int i = 0; i < 9; i++) begin
      step(4);
      total++;
      if ({ActionSel, DogPos_x, DogPos_y} !== {e_as[i], e_x[i], 9'd400}) begin
        bad++;
        $display("FAIL sit_walk_l_tick%0d: got as=%0d x=%0d y=%0d, want as=%0d x=%0d y=400",
                 i + 1, ActionSel, DogPos_x, DogPos_y, e_as[i], e_x[i]);
      end
    end
  endtask

  // Counter is 0 here (tick just fired) with x=16, as=1.
  task automatic test_pause();
    step(2);
    run = 1'b0;
    step(10);
    total++;
    if ({ActionSel, DogPos_x} !== {3'd1, 10'd16}) begin
      bad++;
      $display("FAIL pause_hold: got as=%0d x=%0d, want as=1 x=16", ActionSel, DogPos_x);
    end
    run = 1'b1;
    step(1);
    total++;
    if ({ActionSel, DogPos_x} !== {3'd1, 10'd16}) begin
      bad++;
      $display("FAIL resume_early: got as=%0d x=%0d, want as=1 x=16", ActionSel, DogPos_x);
    end
    step(1);
    total++;
    if ({ActionSel, DogPos_x} !== {3'd0, 10'd32}) begin
      bad++;
      $display("FAIL resume_tick: got as=%0d x=%0d, want as=0 x=32", ActionSel, DogPos_x);
    end
    // Drop run exactly on the cycle the tick would fire.
    step(3);
    run = 1'b0;
    step(5);
    total++;
    if ({ActionSel, DogPos_x} !== {3'd0, 10'd32}) begin
      bad++;
      $display("FAIL pause_at_tick: got as=%0d x=%0d, want as=0 x=32", ActionSel, DogPos_x);
    end
    run = 1'b1;
    step(1);
    total++;
    if ({ActionSel, DogPos_x} !== {3'd1, 10'd48}) begin
      bad++;
      $display("FAIL pause_at_tick_resume: got as=%0d x=%0d, want as=1 x=48",
               ActionSel, DogPos_x);
    end
  endtask

  // From x=48 walking right: 64(sit), 64(sit), 64(as2), 48(as3), 32(as2).
  task automatic test_reset_mid_walk();
    step(20);
    total++;
    if ({ActionSel, DogPos_x} !== {3'd2, 10'd32}) begin
      bad++;
      $display("FAIL walk_l_x32: got as=%0d x=%0d, want as=2 x=32", ActionSel, DogPos_x);
    end
    step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    total++;
    if ({ActionSel, DogPos_x, DogPos_y} !== {3'd0, 10'd0, 9'd400}) begin
      bad++;
      $display("FAIL reset_mid_walk: got as=%0d x=%0d y=%0d, want as=0 x=0 y=400",
               ActionSel, DogPos_x, DogPos_y);
    end
    step(3);
    total++;
    if ({ActionSel, DogPos_x} !== {3'd0, 10'd0}) begin
      bad++;
      $display("FAIL post_reset_early: got as=%0d x=%0d, want as=0 x=0", ActionSel, DogPos_x);
    end
    step(1);
    total++;
    if ({ActionSel, DogPos_x} !== {3'd1, 10'd16}) begin
      bad++;
      $display("FAIL post_reset_tick: got as=%0d x=%0d, want as=1 x=16", ActionSel, DogPos_x);
    end
  endtask

  initial begin
    test_reset();
    test_walk_right();
    test_sit_walk_left();
    test_pause();
    test_reset_mid_walk();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

endmodule
